// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the parametrised FIFO
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register array with one synchronous write and one asynchronous read port
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with thresholds, fill count, sticky errors and FWFT mode
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FWFT       = FIFO_STD,
  parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] dout_q, rd_data;
  logic                  ovf_q, udf_q;
  logic                  wr_req, rd_req, wr_acc, rd_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_req = wr_cs & wr_en;
  assign rd_req = rd_cs & rd_en;
  assign rd_acc = rd_req & ~empty;
  // A full FIFO still takes a write when the same edge frees a slot.
  assign wr_acc = wr_req & (~full | rd_acc);

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // In FWFT mode this tracks the head so the output stays stable once empty.
      if (FWFT == FIFO_FWFT) begin
        if (!empty) dout_q <= rd_data;
      end else if (rd_acc) begin
        dout_q <= rd_data;
      end
      if (wr_req && !wr_acc) ovf_q <= 1'b1;
      else if (clr_err)      ovf_q <= 1'b0;
      if (rd_req && empty)   udf_q <= 1'b1;
      else if (clr_err)      udf_q <= 1'b0;
    end
  end

  assign data_out = ((FWFT == FIFO_FWFT) && !empty) ? rd_data : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_cs = 1'b0, wr_en = 1'b0, rd_cs = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] s_cnt, f_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
    .rd_cs(rd_cs), .rd_en(rd_en), .data_out(s_dout), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf),
    .underflow(s_udf), .clr_err(clr_err)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_cs(wr_cs), .wr_en(wr_en), .data_in(data_in),
    .rd_cs(rd_cs), .rd_en(rd_en), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf),
    .underflow(f_udf), .clr_err(clr_err)
  );

  // One clock with the given requests, then idle inputs and settle 1ns past the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_cs = w; wr_en = w; data_in = d; rd_cs = r; rd_en = r; clr_err = c;
    @(posedge clk); #1;
    wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin n_fail++; $display("FAIL reset_std_flags: got %b expected 1010", {s_empty, s_full, s_ae, s_af}); end
    n_tests++; if (s_cnt !== 3'd0 || s_dout !== 8'h00) begin n_fail++; $display("FAIL reset_std_cnt_dout: got %0d/%h expected 0/00", s_cnt, s_dout); end
    n_tests++; if ({s_ovf, s_udf} !== 2'b00) begin n_fail++; $display("FAIL reset_std_err: got %b expected 00", {s_ovf, s_udf}); end
    n_tests++; if ({f_empty, f_full, f_ae, f_af, f_ovf, f_udf} !== 6'b101000) begin n_fail++; $display("FAIL reset_fwft_flags: got %b expected 101000", {f_empty, f_full, f_ae, f_af, f_ovf, f_udf}); end
    n_tests++; if (f_cnt !== 3'd0 || f_dout !== 8'h00) begin n_fail++; $display("FAIL reset_fwft_cnt_dout: got %0d/%h expected 0/00", f_cnt, f_dout); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    n_tests++; if ({s_empty, s_af, s_ae, s_cnt} !== {3'b001, 3'd1}) begin n_fail++; $display("FAIL fill_one: got e/af/ae/cnt %b expected 001_001", {s_empty, s_af, s_ae, s_cnt}); end
    step(1'b1, 8'h22, 1'b0, 1'b0);
    n_tests++; if ({s_af, s_ae} !== 2'b11) begin n_fail++; $display("FAIL fill_two_thresholds: got af/ae %b expected 11", {s_af, s_ae}); end
    step(1'b1, 8'h33, 1'b0, 1'b0);
    n_tests++; if ({s_full, s_ae, s_cnt} !== {2'b00, 3'd3}) begin n_fail++; $display("FAIL fill_three: got full/ae/cnt %b expected 00_011", {s_full, s_ae, s_cnt}); end
    step(1'b1, 8'h44, 1'b0, 1'b0);
    n_tests++; if (s_full !== 1'b1 || s_cnt !== 3'd4) begin n_fail++; $display("FAIL fill_full: got full=%b cnt=%0d expected 1/4", s_full, s_cnt); end
    step(1'b1, 8'h99, 1'b0, 1'b0);
    n_tests++; if (s_ovf !== 1'b1 || s_cnt !== 3'd4 || s_full !== 1'b1) begin n_fail++; $display("FAIL overflow: got ovf=%b cnt=%0d full=%b expected 1/4/1", s_ovf, s_cnt, s_full); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (s_dout !== exp_q[i]) begin n_fail++; $display("FAIL drain_%0d: got %h expected %h", i, s_dout, exp_q[i]); end
    end
    n_tests++; if ({s_empty, s_cnt, s_udf} !== {1'b1, 3'd0, 1'b0}) begin n_fail++; $display("FAIL drain_empty: got e/cnt/udf %b expected 1_000_0", {s_empty, s_cnt, s_udf}); end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    n_tests++; if (s_dout !== 8'h11 || s_cnt !== 3'd4 || s_ovf !== 1'b0) begin n_fail++; $display("FAIL full_rw: got dout=%h cnt=%0d ovf=%b expected 11/4/0", s_dout, s_cnt, s_ovf); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++; if (s_dout !== exp_q[i]) begin n_fail++; $display("FAIL full_rw_drain_%0d: got %h expected %h", i, s_dout, exp_q[i]); end
    end
  endtask

  task automatic test_empty_rw();
    do_reset();
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    n_tests++; if (s_udf !== 1'b1 || s_cnt !== 3'd1 || s_dout !== 8'h00) begin n_fail++; $display("FAIL empty_rw: got udf=%b cnt=%0d dout=%h expected 1/1/00", s_udf, s_cnt, s_dout); end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_tests++; if (s_udf !== 1'b0) begin n_fail++; $display("FAIL clr_err: got udf=%b expected 0", s_udf); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (s_dout !== 8'hA5 || s_empty !== 1'b1) begin n_fail++; $display("FAIL empty_rw_readback: got dout=%h empty=%b expected A5/1", s_dout, s_empty); end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    n_tests++; if (s_udf !== 1'b1 || s_dout !== 8'hA5) begin n_fail++; $display("FAIL clr_set_wins: got udf=%b dout=%h expected 1/A5", s_udf, s_dout); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      n_tests++; if (s_dout !== 8'(i - 1) || s_cnt !== 3'd1) begin n_fail++; $display("FAIL wrap_%0d: got dout=%h cnt=%0d expected %h/1", i, s_dout, s_cnt, 8'(i - 1)); end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (s_dout !== 8'h09 || s_empty !== 1'b1 || {s_ovf, s_udf} !== 2'b00) begin n_fail++; $display("FAIL wrap_last: got dout=%h empty=%b err=%b expected 09/1/00", s_dout, s_empty, {s_ovf, s_udf}); end
  endtask

  task automatic test_fwft();
    do_reset();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    n_tests++; if (f_dout !== 8'h3C || f_empty !== 1'b0) begin n_fail++; $display("FAIL fwft_head: got dout=%h empty=%b expected 3C/0", f_dout, f_empty); end
    n_tests++; if (s_dout !== 8'h00) begin n_fail++; $display("FAIL std_no_fallthrough: got %h expected 00", s_dout); end
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    n_tests++; if (f_dout !== 8'h5A || f_cnt !== 3'd1) begin n_fail++; $display("FAIL fwft_pop_next: got dout=%h cnt=%0d expected 5A/1", f_dout, f_cnt); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (f_empty !== 1'b1 || f_dout !== 8'h5A) begin n_fail++; $display("FAIL fwft_empty_hold: got empty=%b dout=%h expected 1/5A", f_empty, f_dout); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b1, 1'b0);
    n_tests++; if (s_cnt !== 3'd3 || s_dout !== 8'h01) begin n_fail++; $display("FAIL mid_setup: got cnt=%0d dout=%h expected 3/01", s_cnt, s_dout); end
    wr_cs = 1'b1; wr_en = 1'b1; data_in = 8'hEE;
    #2 rst = 1'b0;
    #1;
    n_tests++; if (s_cnt !== 3'd0 || s_dout !== 8'h00 || {s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 6'b101000) begin n_fail++; $display("FAIL mid_reset: got cnt=%0d dout=%h flags=%b expected 0/00/101000", s_cnt, s_dout, {s_empty, s_full, s_ae, s_af, s_ovf, s_udf}); end
    n_tests++; if (f_cnt !== 3'd0 || f_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_fwft: got cnt=%0d empty=%b expected 0/1", f_cnt, f_empty); end
    wr_cs = 1'b0; wr_en = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_tests++; if (s_dout !== 8'h77 || s_empty !== 1'b1) begin n_fail++; $display("FAIL mid_after: got dout=%h empty=%b expected 77/1", s_dout, s_empty); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_fwft();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO that replaces the fixed 2-bit/4-entry buffer on the Newton-iteration datapath. It buffers operand words between producer and consumer stages and adds true full detection at RAM_DEPTH, almost-full/almost-empty thresholds, a fill count, sticky overflow/underflow flags and a selectable first-word-fall-through read mode.

## Interface
- DATA_WIDTH, 8: width of each stored word.
- ADDR_WIDTH, 4: pointer width; RAM_DEPTH = 2**ADDR_WIDTH entries.
- FWFT, 0: 0 = standard read (registered data_out); 1 = first-word-fall-through.
- AF_LEVEL, RAM_DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_cs  in  1  write chip select.
- wr_en  in  1  write request; effective only with wr_cs.
- data_in  in  DATA_WIDTH  write data.
- rd_cs  in  1  read chip select.
- rd_en  in  1  read request; effective only with rd_cs.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == RAM_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..RAM_DEPTH.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow/underflow.

## Operation
- wr_req = wr_cs & wr_en; rd_req = rd_cs & rd_en.
- rd_acc = rd_req & !empty; wr_acc = wr_req & (!full | rd_acc): write into a full FIFO is accepted only when a read is accepted the same cycle.
- wr_acc: mem[wr_ptr] <= data_in, wr_ptr increments modulo RAM_DEPTH (natural wrap).
- rd_acc: rd_ptr increments modulo RAM_DEPTH.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither; never leaves 0..RAM_DEPTH.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] at the edge; otherwise holds.
- FWFT=1: data_out = mem[rd_ptr] combinationally while !empty; rd_acc pops the shown word; value undefined-but-stable (last head) when empty; no write-to-output bypass, so a word appears the cycle after the write.
- overflow sets on wr_req & !wr_acc; underflow sets on rd_req & empty; both hold until clr_err or reset; clr_err and a new error in the same cycle: set wins.
- Reset (rst low, any time incl. mid-transfer): wr_ptr, rd_ptr, count, data_out = 0; empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0. Memory contents not reset and not relied upon.

## Timing
- All flags and count are registered-state derived; they reflect accepted operations one cycle after the edge that performs them.
- Write latency: word written at edge N is readable (empty deasserted, FWFT head valid) after edge N.
- Read latency: FWFT=0, data_out valid after the rd_acc edge; FWFT=1, zero latency (head visible before the pop).
- Full and empty never assert together (RAM_DEPTH >= 2).
- Reset deassertion is used synchronously by the integrating design; no operation is accepted on the edge coinciding with release.

## Structure
- Package fifo_pkg: FWFT mode constants (FIFO_STD, FIFO_FWFT), default width/depth constants, count-type width helper (ADDR_WIDTH+1).
- Sub-module fifo_mem: DATA_WIDTH x RAM_DEPTH register array, one synchronous write port, one asynchronous read port; no reset. Top holds pointers, count, flags and output register.

## Test plan
- Reset, DATA_WIDTH=8, ADDR_WIDTH=2: write 0x11,0x22,0x33,0x44 -> full=1, count=4 after 4th edge; 5th write -> overflow=1, count stays 4; read 4 -> 0x11..0x44 in order, empty=1.
- Full FIFO, simultaneous read+write of 0x55 -> data_out=0x11, count stays 4, overflow stays 0; 0x55 later read as 5th word.
- Empty FIFO, simultaneous read+write of 0xA5 -> read rejected, underflow=1, count=1; clr_err -> underflow=0.
- Wrap: 10 write/read pairs of 0x00..0x09 through depth 4 -> outputs in order, pointers wrap, count never exceeds 2.
- FWFT=1: write 0x3C to empty -> data_out=0x3C next cycle without rd_en; rd_en -> empty=1 next cycle.
- Assert rst low with count=3 mid-burst -> all outputs at reset values immediately, count=0, subsequent write/read returns new data only.
